fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_unit_pc_counter.sv | 21 ++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode and state encodings plus default widths for the fetch unit.
package fetch_unit_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;

    typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;

    typedef enum logic [1:0] {RUN, HALTED, BREAK} fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: program counter with hold enable, load priority over increment, natural wrap.
module pc_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         en,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            q <= '0;
        else if (en)
            q <= load ? d : inc ? q + 1'b1 : q;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch datapath with RUN/HALTED/BREAK control.
// Breakpoint logic and the BREAK state exist only when FETCH_BKPT_EN is defined.
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              load_ir,
    input  logic              halt,
    input  logic              fetch,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              bkpt_en,
    input  logic [AWIDTH-1:0] bkpt_addr,
    input  logic              resume,
    output opcode_t           opcode,
    output logic [AWIDTH-1:0] ir_addr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [AWIDTH-1:0] pc,
    output logic              halted,
    output logic              bkpt_hit,
    output logic [7:0]        instr_cnt
);

    fetch_state_t      state;
    logic [DWIDTH-1:0] ir;
    logic              ir_prev;
    logic              rise;

    assign opcode   = opcode_t'(ir[DWIDTH-1:DWIDTH-3]);
    assign ir_addr  = ir[AWIDTH-1:0];
    assign mem_addr = fetch ? pc : ir_addr;
    assign rise     = load_ir && !ir_prev;

    pc_counter #(.W(AWIDTH)) u_pc (
        .clk  (clk),
        .rst_ (rst_),
        .en   (state == RUN && !halt),
        .load (load_pc),
        .inc  (inc_pc),
        .d    (ir_addr),
        .q    (pc)
    );

`ifdef FETCH_BKPT_EN
    logic bkpt_q;
    logic bk_match;
    assign bk_match = rise && bkpt_en && pc == bkpt_addr;
    assign bkpt_hit = bkpt_q;
`else
    logic unused_bkpt;
    assign unused_bkpt = ^{bkpt_en, bkpt_addr, resume};
    assign bkpt_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= RUN;
            ir        <= '0;
            ir_prev   <= 1'b0;
            instr_cnt <= '0;
            halted    <= 1'b0;
`ifdef FETCH_BKPT_EN
            bkpt_q    <= 1'b0;
`endif
        end else begin
            ir_prev <= load_ir;
            case (state)
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        if (load_ir)
                            ir <= data_in;
                        if (rise && instr_cnt != 8'hFF)
                            instr_cnt <= instr_cnt + 8'd1;
`ifdef FETCH_BKPT_EN
                        if (bk_match) begin
                            state  <= BREAK;
                            bkpt_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef FETCH_BKPT_EN
                BREAK: begin
                    if (resume) begin
                        state  <= RUN;
                        bkpt_q <= 1'b0;
                    end
                end
`else
                BREAK: state <= RUN;
`endif
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
import fetch_unit_pkg::*;

module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       inc_pc = 1'b0, load_pc = 1'b0, load_ir = 1'b0, halt = 1'b0, fetch = 1'b1;
    logic [7:0] data_in = '0;
    logic       bkpt_en = 1'b0;
    logic [4:0] bkpt_addr = '0;
    logic       resume = 1'b0;
    opcode_t    opcode;
    logic [4:0] ir_addr, mem_addr, pc;
    logic       halted, bkpt_hit;
    logic [7:0] instr_cnt;
    int         n_chk = 0;
    int         n_fail = 0;

    fetch_unit dut (
        .clk       (clk),
        .rst_      (rst_),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .load_ir   (load_ir),
        .halt      (halt),
        .fetch     (fetch),
        .data_in   (data_in),
        .bkpt_en   (bkpt_en),
        .bkpt_addr (bkpt_addr),
        .resume    (resume),
        .opcode    (opcode),
        .ir_addr   (ir_addr),
        .mem_addr  (mem_addr),
        .pc        (pc),
        .halted    (halted),
        .bkpt_hit  (bkpt_hit),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        {inc_pc, load_pc, load_ir, halt, resume, bkpt_en} = '0;
        fetch = 1'b1;
        rst_  = 1'b0;
        tick();
        rst_  = 1'b1;
    endtask

    task automatic test_reset();
        inc_pc = 1'b1;
        load_ir = 1'b1;
        data_in = 8'hFF;
        rst_ = 1'b0;
        tick(2);
        n_chk++; if (pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        n_chk++; if (opcode !== HLT || ir_addr !== 5'd0) begin n_fail++; $display("FAIL reset_ir got=%0d/%0d exp=0/0", opcode, ir_addr); end
        n_chk++; if (instr_cnt !== 8'd0 || halted !== 1'b0 || bkpt_hit !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%0d/%b/%b exp=0/0/0", instr_cnt, halted, bkpt_hit); end
        do_reset();
    endtask

    task automatic test_load_ir();
        do_reset();
        data_in = 8'h65;
        load_ir = 1'b1;
        tick(2);
        load_ir = 1'b0;
        tick();
        n_chk++; if (opcode !== AND || ir_addr !== 5'd5) begin n_fail++; $display("FAIL load_ir_and got=%0d/%0d exp=%0d/5", opcode, ir_addr, AND); end
        n_chk++; if (instr_cnt !== 8'd1) begin n_fail++; $display("FAIL load_ir_cnt got=%0d exp=1", instr_cnt); end
        data_in = 8'hA5;
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
        data_in = 8'h00;
        tick();
        n_chk++; if (opcode !== LDA || ir_addr !== 5'd5 || instr_cnt !== 8'd2) begin n_fail++; $display("FAIL load_ir_lda got=%0d/%0d/%0d exp=%0d/5/2", opcode, ir_addr, instr_cnt, LDA); end
    endtask

    task automatic test_pc();
        do_reset();
        inc_pc = 1'b1;
        tick(31);
        n_chk++; if (pc !== 5'd31) begin n_fail++; $display("FAIL pc_inc got=%0d exp=31", pc); end
        tick();
        n_chk++; if (pc !== 5'd0) begin n_fail++; $display("FAIL pc_wrap got=%0d exp=0", pc); end
        inc_pc = 1'b0;
        data_in = 8'h09;
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
        load_pc = 1'b1;
        inc_pc = 1'b1;
        tick();
        n_chk++; if (pc !== 5'd9) begin n_fail++; $display("FAIL pc_load_prio got=%0d exp=9", pc); end
        load_pc = 1'b0;
        tick();
        inc_pc = 1'b0;
        fetch = 1'b1;
        #1;
        n_chk++; if (mem_addr !== 5'd10) begin n_fail++; $display("FAIL mem_addr_pc got=%0d exp=10", mem_addr); end
        fetch = 1'b0;
        #1;
        n_chk++; if (mem_addr !== 5'd9) begin n_fail++; $display("FAIL mem_addr_ir got=%0d exp=9", mem_addr); end
        fetch = 1'b1;
    endtask

    task automatic test_halt();
        do_reset();
        inc_pc = 1'b1;
        tick(4);
        halt = 1'b1;
        load_ir = 1'b1;
        data_in = 8'hFF;
        tick();
        halt = 1'b0;
        n_chk++; if (halted !== 1'b1 || pc !== 5'd4) begin n_fail++; $display("FAIL halt_enter got=%b/%0d exp=1/4", halted, pc); end
        n_chk++; if (opcode !== HLT || instr_cnt !== 8'd0) begin n_fail++; $display("FAIL halt_suppress got=%0d/%0d exp=0/0", opcode, instr_cnt); end
        for (int i = 0; i < 6; i++) begin
            load_ir = i[0];
            load_pc = i[1];
            resume = 1'b1;
            tick();
        end
        resume = 1'b0;
        {load_ir, load_pc, inc_pc} = '0;
        n_chk++; if (halted !== 1'b1 || pc !== 5'd4 || instr_cnt !== 8'd0 || opcode !== HLT) begin n_fail++; $display("FAIL halt_hold got=%b/%0d/%0d/%0d exp=1/4/0/0", halted, pc, instr_cnt, opcode); end
        fetch = 1'b1;
        #1;
        n_chk++; if (mem_addr !== 5'd4) begin n_fail++; $display("FAIL halt_mem_addr got=%0d exp=4", mem_addr); end
        #2;
        rst_ = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b0 || pc !== 5'd0) begin n_fail++; $display("FAIL halt_async_reset got=%b/%0d exp=0/0", halted, pc); end
        tick();
        rst_ = 1'b1;
    endtask

    task automatic test_bkpt();
        do_reset();
        inc_pc = 1'b1;
        tick(3);
        inc_pc = 1'b0;
        bkpt_addr = 5'd3;
        bkpt_en = 1'b1;
        data_in = 8'h47;
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
        inc_pc = 1'b1;
        tick(2);
        n_chk++; if (opcode !== ADD || ir_addr !== 5'd7 || instr_cnt !== 8'd1) begin n_fail++; $display("FAIL bkpt_ir got=%0d/%0d/%0d exp=%0d/7/1", opcode, ir_addr, instr_cnt, ADD); end
`ifdef FETCH_BKPT_EN
        n_chk++; if (bkpt_hit !== 1'b1 || pc !== 5'd3) begin n_fail++; $display("FAIL bkpt_freeze got=%b/%0d exp=1/3", bkpt_hit, pc); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_chk++; if (bkpt_hit !== 1'b0 || pc !== 5'd3) begin n_fail++; $display("FAIL bkpt_resume got=%b/%0d exp=0/3", bkpt_hit, pc); end
        tick();
        n_chk++; if (bkpt_hit !== 1'b0 || pc !== 5'd4) begin n_fail++; $display("FAIL bkpt_continue got=%b/%0d exp=0/4", bkpt_hit, pc); end
`else
        n_chk++; if (bkpt_hit !== 1'b0 || pc !== 5'd5) begin n_fail++; $display("FAIL bkpt_disabled got=%b/%0d exp=0/5", bkpt_hit, pc); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_chk++; if (bkpt_hit !== 1'b0 || pc !== 5'd6) begin n_fail++; $display("FAIL bkpt_disabled_run got=%b/%0d exp=0/6", bkpt_hit, pc); end
`endif
        inc_pc = 1'b0;
        bkpt_en = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        data_in = 8'h20;
        for (int i = 0; i < 300; i++) begin
            load_ir = 1'b1;
            tick();
            load_ir = 1'b0;
            tick();
            if (i == 253) begin
                n_chk++; if (instr_cnt !== 8'd254) begin n_fail++; $display("FAIL cnt_254 got=%0d exp=254", instr_cnt); end
            end
        end
        n_chk++; if (instr_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_saturate got=%0d exp=255", instr_cnt); end
        n_chk++; if (opcode !== SKZ) begin n_fail++; $display("FAIL cnt_opcode got=%0d exp=%0d", opcode, SKZ); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inc_pc = 1'b1;
        data_in = 8'hE3;
        load_ir = 1'b1;
        tick(2);
        #2;
        rst_ = 1'b0;
        #1;
        n_chk++; if (pc !== 5'd0 || opcode !== HLT || instr_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset got=%0d/%0d/%0d exp=0/0/0", pc, opcode, instr_cnt); end
        load_ir = 1'b0;
        tick();
        rst_ = 1'b1;
        tick();
        n_chk++; if (pc !== 5'd1 || halted !== 1'b0) begin n_fail++; $display("FAIL mid_reset_run got=%0d/%b exp=1/0", pc, halted); end
        inc_pc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_ir();
        test_pc();
        test_halt();
        test_bkpt();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
